// File: rtl/enc_2to1.sv
// enc_2to1 -- registered 2-to-1 word selector.
// On each enabled clock edge one of two WIDTH-bit sources, chosen by mux_sel,
// is captured into the output register. The block also reports which source
// is held, whether the held data is valid, and pulses when the chosen source
// changes between consecutive valid loads.
// Optional feature: define ENC_2TO1_PARITY_EN to add a registered even-parity
// output (mux_parity) alongside mux_out.
module enc_2to1 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] mux_input_0,
  input  logic [WIDTH-1:0] mux_input_1,
  input  logic             mux_sel,
  input  logic             mux_en,
  output logic [WIDTH-1:0] mux_out,
  output logic             mux_valid,
  output logic             mux_sel_q,
`ifdef ENC_2TO1_PARITY_EN
  output logic             mux_sel_chg,
  output logic             mux_parity
`else
  output logic             mux_sel_chg
`endif
);

  logic [WIDTH-1:0] out_q,   out_d;
  logic             valid_q, valid_d;
  logic             sel_q,   sel_d;
  logic             chg_q,   chg_d;

  // Word picked by the current select; only captured when mux_en is high.
  logic [WIDTH-1:0] picked_word;
  assign picked_word = mux_sel ? mux_input_1 : mux_input_0;

  // Next-state logic: load the picked word or hold; the change pulse only
  // fires on a load that follows an earlier valid load with another select.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    chg_d   = 1'b0;
    if (mux_en) begin
      out_d   = picked_word;
      valid_d = 1'b1;
      sel_d   = mux_sel;
      chg_d   = valid_q & (mux_sel != sel_q);
    end
  end

  // State registers; clr wins over any load at the same edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      sel_q   <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      chg_q   <= chg_d;
    end
  end

  assign mux_out     = out_q;
  assign mux_valid   = valid_q;
  assign mux_sel_q   = sel_q;
  assign mux_sel_chg = chg_q;

`ifdef ENC_2TO1_PARITY_EN
  logic parity_q, parity_d;

  // Parity tracks the word being loaded so it always matches mux_out.
  always_comb begin
    parity_d = parity_q;
    if (mux_en) begin
      parity_d = ^picked_word;
    end
  end

  // Parity register, cleared together with the data register.
  always_ff @(posedge clk) begin
    if (clr) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign mux_parity = parity_q;
`endif

endmodule

// File: tb/tb_enc_2to1.sv
// Directed testbench for enc_2to1 with hand-computed expected values.
// Exercises the parity output too when ENC_2TO1_PARITY_EN is defined.
module tb_enc_2to1;

  logic        clk;
  logic        clr;
  logic [31:0] mux_input_0;
  logic [31:0] mux_input_1;
  logic        mux_sel;
  logic        mux_en;
  logic [31:0] mux_out;
  logic        mux_valid;
  logic        mux_sel_q;
  logic        mux_sel_chg;
`ifdef ENC_2TO1_PARITY_EN
  logic        mux_parity;
`endif

  int n_vectors;
  int n_miscompares;

  enc_2to1 #(.WIDTH(32)) dut (
    .clk        (clk),
    .clr        (clr),
    .mux_input_0(mux_input_0),
    .mux_input_1(mux_input_1),
    .mux_sel    (mux_sel),
    .mux_en     (mux_en),
    .mux_out    (mux_out),
    .mux_valid  (mux_valid),
    .mux_sel_q  (mux_sel_q),
`ifdef ENC_2TO1_PARITY_EN
    .mux_sel_chg(mux_sel_chg),
    .mux_parity (mux_parity)
`else
    .mux_sel_chg(mux_sel_chg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
    n_vectors++;
    if (observed !== expected) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end else begin
      $display("ok   %s: 0x%08h", tag, observed);
    end
  endtask

  // One clock edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_out,
                           input logic e_valid, input logic e_selq,
                           input logic e_chg);
    check_val({tag, ".out"},   mux_out, e_out);
    check_val({tag, ".valid"}, 32'(mux_valid), 32'(e_valid));
    check_val({tag, ".selq"},  32'(mux_sel_q), 32'(e_selq));
    check_val({tag, ".chg"},   32'(mux_sel_chg), 32'(e_chg));
  endtask

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    clr = 1'b1; mux_en = 1'b1; mux_sel = 1'b0;
    mux_input_0 = 32'd15; mux_input_1 = 32'd240;

    // Reset overrides an enabled load.
    step();
    check_all("reset", 32'd0, 1'b0, 1'b0, 1'b0);
`ifdef ENC_2TO1_PARITY_EN
    check_val("reset.par", 32'(mux_parity), 32'd0);
`endif

    // First load, select 0: no change pulse.
    clr = 1'b0;
    step();
    check_all("sel0", 32'd15, 1'b1, 1'b0, 1'b0);
`ifdef ENC_2TO1_PARITY_EN
    check_val("sel0.par", 32'(mux_parity), 32'd0);
`endif

    // Switch to select 1: one-cycle change pulse.
    mux_sel = 1'b1;
    step();
    check_all("sw1", 32'd240, 1'b1, 1'b1, 1'b1);

    // Same select again: pulse drops.
    step();
    check_all("same1", 32'd240, 1'b1, 1'b1, 1'b0);

    // Hold: inputs and select move, outputs do not.
    mux_en = 1'b0;
    mux_input_0 = 32'hFFFF_FFFF; mux_input_1 = 32'hA5A5_A5A5;
    for (int i = 0; i < 3; i++) begin
      mux_sel = ~mux_sel;
      step();
      check_all($sformatf("hold%0d", i), 32'd240, 1'b1, 1'b1, 1'b0);
    end

    // Load source 0 after a valid load from source 1: pulse.
    mux_en = 1'b1; mux_sel = 1'b0;
    step();
    check_all("sw0", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
`ifdef ENC_2TO1_PARITY_EN
    check_val("sw0.par", 32'(mux_parity), 32'd0);
`endif

    // Reset mid-stream discards the load at that edge.
    clr = 1'b1; mux_sel = 1'b1;
    step();
    check_all("rstmid", 32'd0, 1'b0, 1'b0, 1'b0);

    // Next load is a first load: no pulse even though select is 1.
    clr = 1'b0;
    step();
    check_all("first1", 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b0);

    // Select and data change together at the load edge.
    mux_sel = 1'b0; mux_input_0 = 32'h0000_0007; mux_input_1 = 32'h1234_5678;
    step();
    check_all("load7", 32'h0000_0007, 1'b1, 1'b0, 1'b1);
`ifdef ENC_2TO1_PARITY_EN
    check_val("load7.par", 32'(mux_parity), 32'd1);
`endif

    // Unchanged select, new data: data updates, no pulse.
    mux_input_0 = 32'h0000_0003;
    step();
    check_all("load3", 32'h0000_0003, 1'b1, 1'b0, 1'b0);
`ifdef ENC_2TO1_PARITY_EN
    check_val("load3.par", 32'(mux_parity), 32'd0);
    // Parity holds while not loading.
    mux_en = 1'b0; mux_input_0 = 32'h0000_0001;
    step();
    check_val("hold3.par", 32'(mux_parity), 32'd0);
    check_val("hold3.out", mux_out, 32'h0000_0003);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
